// File: rtl/ex_muldiv.sv
// ex_muldiv: execute stage with single-cycle logic/shift/move ops, a
// single-cycle multiplier into HI/LO and a radix-2 restoring divider that
// holds the pipeline while it iterates.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  abort in-flight divide / suppress HI/LO writes
//   aluop_i, alusel_i        operation subtype and result class
//   wd_i, wreg_i             destination register and write request
//   reg1_i, reg2_i           operands (reg1_i[..] is the shift amount)
//   wd_o, wreg_o, wdata_o    writeback destination, enable and data
//   stall_req_o              pipeline hold request
//   hi_o, lo_o               HI/LO architectural registers
//
// Divider states:
//   state  | meaning
//   S_IDLE | accept ops; DIV/DIVU latches operands and stalls
//   S_BUSY | one shift-subtract step per cycle, stalling
//   S_DONE | apply signs, write HI/LO, release the pipeline
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h12;

  localparam logic [2:0] SEL_LOGIC  = 3'b001;
  localparam logic [2:0] SEL_SHIFT  = 3'b010;
  localparam logic [2:0] SEL_MOVE   = 3'b011;

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} div_state_t;

  div_state_t        state;
  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] dv_q;   // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] dv_r;   // partial remainder
  logic [DATA_W-1:0] dv_d;   // divisor magnitude
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;

  logic is_mult, is_div, is_signed, div_start;
  logic [SH_W-1:0]     sh;
  logic [2*DATA_W-1:0] ext1, ext2, prod;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     trial_r, trial_diff;
  logic                fits;
  logic [DATA_W-1:0]   next_q, next_r, q_final, r_final;

  assign is_mult   = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
  assign div_start = (state == S_IDLE) && is_div && !flush_i;
  assign sh        = reg1_i[SH_W-1:0];

  // Sign- or zero-extend to 2*DATA_W; the low half of the wide product is
  // then the correct result for both signed and unsigned multiply.
  assign ext1 = {{DATA_W{is_signed & reg1_i[DATA_W-1]}}, reg1_i};
  assign ext2 = {{DATA_W{is_signed & reg2_i[DATA_W-1]}}, reg2_i};
  assign prod = ext1 * ext2;

  assign abs1 = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
  assign abs2 = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

  assign trial_r    = {dv_r, dv_q[DATA_W-1]};
  assign trial_diff = trial_r - {1'b0, dv_d};
  assign fits       = !trial_diff[DATA_W];
  assign next_r     = fits ? trial_diff[DATA_W-1:0] : trial_r[DATA_W-1:0];
  assign next_q     = {dv_q[DATA_W-2:0], fits};

  assign q_final = neg_q ? -dv_q : dv_q;
  assign r_final = neg_r ? -dv_r : dv_r;

  assign wd_o   = wd_i;
  assign wreg_o = wreg_i && !is_mult && !is_div;
  assign hi_o   = hi;
  assign lo_o   = lo;

  // The DIV op is held on the inputs while stalled, so stall must drop in
  // DONE or the pipeline would never advance past it.
  assign stall_req_o = div_start || ((state == S_BUSY) && !flush_i);

  always_comb begin
    wdata_o = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  wdata_o = reg1_i & reg2_i;
          OP_OR:   wdata_o = reg1_i | reg2_i;
          OP_XOR:  wdata_o = reg1_i ^ reg2_i;
          OP_NOR:  wdata_o = ~(reg1_i | reg2_i);
          default: wdata_o = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  wdata_o = reg2_i << sh;
          OP_SRL:  wdata_o = reg2_i >> sh;
          OP_SRA:  wdata_o = $signed(reg2_i) >>> sh;
          default: wdata_o = '0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: wdata_o = hi;
          OP_MFLO: wdata_o = lo;
          default: wdata_o = '0;
        endcase
      end
      default: wdata_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      dv_q  <= '0;
      dv_r  <= '0;
      dv_d  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush_i) begin
            if (is_mult) begin
              hi <= prod[2*DATA_W-1:DATA_W];
              lo <= prod[DATA_W-1:0];
            end
            if (is_div) begin
              if (reg2_i == '0) begin
                // Divide by zero: fixed result, no iteration, no sign fix-up.
                dv_q  <= '1;
                dv_r  <= reg1_i;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= S_DONE;
              end else begin
                dv_q  <= abs1;
                dv_r  <= '0;
                dv_d  <= abs2;
                neg_q <= is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                neg_r <= is_signed && reg1_i[DATA_W-1];
                cnt   <= '0;
                state <= S_BUSY;
              end
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            dv_q <= next_q;
            dv_r <= next_r;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!flush_i) begin
            hi <= r_final;
            lo <= q_final;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
